// File: rtl/miner_pkg.sv
// ============================================================================
// Module      : miner_pkg
// Description : Shared opcodes, controller state encoding and status-bit map.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package miner_pkg;

  localparam logic [7:0] c_OP_LOAD       = 8'h01;
  localparam logic [7:0] c_OP_READ_STAT  = 8'h02;
  localparam logic [7:0] c_OP_READ_NONCE = 8'h03;
  localparam logic [7:0] c_OP_ABORT      = 8'h04;

  localparam int c_STAT_FOUND   = 0;
  localparam int c_STAT_BUSY    = 1;
  localparam int c_STAT_JOBV    = 2;
  localparam int c_STAT_OVERRUN = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CMD        = 3'd1,
    ST_LOAD       = 3'd2,
    ST_READ_STAT  = 3'd3,
    ST_READ_NONCE = 3'd4,
    ST_DISCARD    = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/job_shift_buffer.sv
// ============================================================================
// Module      : job_shift_buffer
// Description : Shadow buffer assembling header bytes; the newest byte enters
//               at the top so byte 0 ends up in bits [7:0].
// Revision    : 1.0
// ============================================================================
`default_nettype none

module job_shift_buffer #(
  parameter int BYTES = 76
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               shift_en_i,
  input  logic [7:0]         byte_i,
  output logic [BYTES*8-1:0] assembled_o
);

  localparam int c_SW = (BYTES - 1) * 8;

  logic [c_SW-1:0] shadow_q;

  // assembled_o already includes byte_i so the final byte can be committed
  // in the same cycle it arrives.
  assign assembled_o = {byte_i, shadow_q};

  generate
    if (BYTES > 2) begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          shadow_q <= '0;
        else if (shift_en_i) shadow_q <= {byte_i, shadow_q[c_SW-1:8]};
      end
    end else begin : g_pair
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          shadow_q <= '0;
        else if (shift_en_i) shadow_q <= byte_i;
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_job_controller.sv
// ============================================================================
// Module      : spi_job_controller
// Description : SPI command decoder loading hasher jobs and reporting nonces.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module spi_job_controller
  import miner_pkg::*;
#(
  parameter int JOB_BYTES   = 76,
  parameter int NONCE_BYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     chip_enable,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_byte,
  input  logic                     send_byte,
  output logic [7:0]               tx_byte,
  output logic [JOB_BYTES*8-1:0]   job_data,
  output logic                     job_valid,
  input  logic                     job_ready,
  input  logic                     hash_busy,
  input  logic                     nonce_valid,
  input  logic [NONCE_BYTES*8-1:0] nonce,
  output logic                     abort
);

  localparam int c_MAXB = (JOB_BYTES > NONCE_BYTES) ? JOB_BYTES : NONCE_BYTES;
  localparam int c_CW   = $clog2(c_MAXB + 1);

  state_e                   state_q, state_d;
  logic [c_CW-1:0]          cnt_q, cnt_d;
  logic                     ce_q;
  logic                     job_valid_q, job_valid_d;
  logic [JOB_BYTES*8-1:0]   job_data_q;
  logic                     abort_q, abort_d;
  logic                     found_q, found_d;
  logic                     overrun_q, overrun_d;
  logic [NONCE_BYTES*8-1:0] nonce_reg_q, nonce_reg_d;

  logic                     w_shift_en;
  logic                     w_job_commit;
  logic                     w_nonce_done;
  logic [JOB_BYTES*8-1:0]   w_assembled;
  logic [7:0]               w_status;
  logic [7:0]               w_nonce_byte;

  job_shift_buffer #(.BYTES(JOB_BYTES)) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .shift_en_i  (w_shift_en),
    .byte_i      (rx_byte),
    .assembled_o (w_assembled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ce_q        <= 1'b0;
      job_valid_q <= 1'b0;
      job_data_q  <= '0;
      abort_q     <= 1'b0;
      found_q     <= 1'b0;
      overrun_q   <= 1'b0;
      nonce_reg_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ce_q        <= chip_enable;
      job_valid_q <= job_valid_d;
      abort_q     <= abort_d;
      found_q     <= found_d;
      overrun_q   <= overrun_d;
      nonce_reg_q <= nonce_reg_d;
      if (w_job_commit) job_data_q <= w_assembled;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    job_valid_d  = job_valid_q;
    abort_d      = 1'b0;
    w_shift_en   = 1'b0;
    w_job_commit = 1'b0;

    if (job_valid_q && job_ready) job_valid_d = 1'b0;

    if (chip_enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        // ce_q resets low so a frame already open at reset release is ignored.
        ST_IDLE: if (ce_q) state_d = ST_CMD;
        ST_CMD: begin
          if (rx_valid) begin
            unique case (rx_byte)
              c_OP_LOAD:       state_d = ST_LOAD;
              c_OP_READ_STAT:  state_d = ST_READ_STAT;
              c_OP_READ_NONCE: state_d = ST_READ_NONCE;
              c_OP_ABORT: begin
                abort_d     = 1'b1;
                job_valid_d = 1'b0;
                state_d     = ST_DISCARD;
              end
              default:         state_d = ST_DISCARD;
            endcase
          end
        end
        ST_LOAD: begin
          if (rx_valid) begin
            w_shift_en = 1'b1;
            cnt_d      = cnt_q + c_CW'(1);
            if (cnt_q == c_CW'(JOB_BYTES - 1)) begin
              w_job_commit = 1'b1;
              job_valid_d  = 1'b1;
              state_d      = ST_DISCARD;
            end
          end
        end
        ST_READ_NONCE: begin
          if (send_byte && (cnt_q < c_CW'(NONCE_BYTES))) cnt_d = cnt_q + c_CW'(1);
        end
        ST_READ_STAT: ;
        ST_DISCARD:   ;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  assign w_nonce_done = (state_q == ST_READ_NONCE) && send_byte &&
                        (cnt_q == c_CW'(NONCE_BYTES - 1));

  // Consumption clears first, so a coincident find is captured as a fresh one.
  always_comb begin
    found_d     = found_q;
    overrun_d   = overrun_q;
    nonce_reg_d = nonce_reg_q;
    if (w_nonce_done) begin
      found_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (nonce_valid) begin
      if (!found_d) begin
        nonce_reg_d = nonce;
        found_d     = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    w_status                 = 8'h00;
    w_status[c_STAT_FOUND]   = found_q;
    w_status[c_STAT_BUSY]    = hash_busy;
    w_status[c_STAT_JOBV]    = job_valid_q;
    w_status[c_STAT_OVERRUN] = overrun_q;
  end

  always_comb begin
    w_nonce_byte = 8'h00;
    for (int i = 0; i < NONCE_BYTES; i++) begin
      if (cnt_q == c_CW'(i)) w_nonce_byte = nonce_reg_q[i*8 +: 8];
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    if (state_q == ST_READ_STAT)       tx_byte = w_status;
    else if (state_q == ST_READ_NONCE) tx_byte = w_nonce_byte;
  end

  assign job_data  = job_data_q;
  assign job_valid = job_valid_q;
  assign abort     = abort_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_job_controller.sv
// ============================================================================
// Module      : tb_spi_job_controller
// Description : Randomized scoreboard bench for spi_job_controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_job_controller;

  localparam int JB = 76;
  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            chip_enable = 1'b1;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_byte = 8'h00;
  logic            send_byte = 1'b0;
  logic [7:0]      tx_byte;
  logic [JB*8-1:0] job_data;
  logic            job_valid;
  logic            job_ready = 1'b0;
  logic            hash_busy = 1'b0;
  logic            nonce_valid = 1'b0;
  logic [NB*8-1:0] nonce = '0;
  logic            abort;

  int errors = 0;
  int checks = 0;

  logic [7:0]      exp_tx_q[$];
  logic [JB*8-1:0] exp_job_q[$];

  // Reference model state
  logic            m_found = 1'b0;
  logic            m_overrun = 1'b0;
  logic            m_job_valid = 1'b0;
  logic [NB*8-1:0] m_nonce = '0;
  logic [JB*8-1:0] m_job_data = '0;

  spi_job_controller #(.JOB_BYTES(JB), .NONCE_BYTES(NB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .chip_enable (chip_enable),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .send_byte   (send_byte),
    .tx_byte     (tx_byte),
    .job_data    (job_data),
    .job_valid   (job_valid),
    .job_ready   (job_ready),
    .hash_busy   (hash_busy),
    .nonce_valid (nonce_valid),
    .nonce       (nonce),
    .abort       (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_job(input string name, input logic [JB*8-1:0] act, input logic [JB*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops scoreboard entries whenever the DUT hands something over.
  always @(negedge clk) begin
    if (rst_n && job_valid && job_ready) begin
      if (exp_job_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL job_accept: unexpected job %h", job_data);
      end else begin
        chk_job("job_accept", job_data, exp_job_q.pop_front());
      end
    end
    if (send_byte) begin
      if (exp_tx_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_byte: unexpected send_byte, tx=%0h", tx_byte);
      end else begin
        chk("tx_byte", {24'h0, tx_byte}, {24'h0, exp_tx_q.pop_front()});
      end
    end
  end

  function automatic logic [7:0] status_byte();
    return {4'b0, m_overrun, m_job_valid, hash_busy, m_found};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0; tick(); tick();
  endtask

  task automatic open_frame(input logic [7:0] op);
    chip_enable = 1'b0; tick(); tick();
    send_rx(op);
  endtask

  task automatic close_frame();
    chip_enable = 1'b1; tick(); tick();
  endtask

  task automatic send_tx(input logic [7:0] expb);
    exp_tx_q.push_back(expb);
    send_byte = 1'b1; tick(); send_byte = 1'b0; tick();
  endtask

  task automatic pulse_nonce(input logic [NB*8-1:0] n);
    nonce = n; nonce_valid = 1'b1;
    if (!m_found) begin m_found = 1'b1; m_nonce = n; end
    else m_overrun = 1'b1;
    tick(); nonce_valid = 1'b0; tick();
  endtask

  task automatic set_ready(input logic v);
    job_ready = v;
    if (v && m_job_valid) begin
      exp_job_q.push_back(m_job_data);
      m_job_valid = 1'b0;
    end
    tick();
  endtask

  task automatic full_load(input logic [JB*8-1:0] data, input int extra);
    open_frame(8'h01);
    for (int i = 0; i < JB - 1; i++) send_rx(data[i*8 +: 8]);
    rx_byte = data[(JB-1)*8 +: 8]; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("job_valid_rise", {31'h0, job_valid}, 32'h1);
    chk_job("job_data_commit", job_data, data);
    m_job_data = data;
    if (job_ready) exp_job_q.push_back(data);
    else m_job_valid = 1'b1;
    tick();
    chk("job_valid_after", {31'h0, job_valid}, {31'h0, m_job_valid});
    for (int i = 0; i < extra; i++) send_rx(8'($urandom));
    close_frame();
    chk_job("job_data_hold", job_data, m_job_data);
  endtask

  task automatic short_load(input int n);
    open_frame(8'h01);
    for (int i = 0; i < n; i++) send_rx(8'($urandom));
    close_frame();
    chk("trunc_job_valid", {31'h0, job_valid}, {31'h0, m_job_valid});
    chk_job("trunc_job_data", job_data, m_job_data);
  endtask

  task automatic nonce_read(input int nsb);
    open_frame(8'h03);
    for (int k = 0; k < nsb; k++) begin
      send_tx((k < NB) ? m_nonce[k*8 +: 8] : 8'h00);
      if (k == NB - 1) begin m_found = 1'b0; m_overrun = 1'b0; end
    end
    close_frame();
  endtask

  task automatic status_read(input int n);
    open_frame(8'h02);
    for (int k = 0; k < n; k++) send_tx(status_byte());
    close_frame();
  endtask

  task automatic abort_op();
    chip_enable = 1'b0; tick(); tick();
    rx_byte = 8'h04; rx_valid = 1'b1; tick(); rx_valid = 1'b0;
    chk("abort_high", {31'h0, abort}, 32'h1);
    chk("abort_job_valid", {31'h0, job_valid}, 32'h0);
    m_job_valid = 1'b0;
    tick();
    chk("abort_low", {31'h0, abort}, 32'h0);
    tick();
    close_frame();
  endtask

  task automatic rand_job(output logic [JB*8-1:0] d);
    for (int i = 0; i < JB; i++) d[i*8 +: 8] = 8'($urandom);
  endtask

  function automatic void model_reset();
    m_found = 1'b0; m_overrun = 1'b0; m_job_valid = 1'b0;
    m_nonce = '0; m_job_data = '0;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx"}, {24'h0, tx_byte}, 32'h0);
    chk({tag, "_job_valid"}, {31'h0, job_valid}, 32'h0);
    chk({tag, "_abort"}, {31'h0, abort}, 32'h0);
    chk_job({tag, "_job_data"}, job_data, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [JB*8-1:0] d;
    logic [JB*8-1:0] inc;
    int op;

    for (int i = 0; i < JB; i++) inc[i*8 +: 8] = 8'(i);

    tick(); tick();
    chk_reset_outputs("reset_hold");
    rst_n = 1'b1; tick(); tick();
    chk_reset_outputs("reset_rel");
    status_read(2);

    // Counting-pattern load with hasher ready, plus trailing bytes to discard
    set_ready(1'b1);
    full_load(inc, 3);
    chk("load_byte0", {24'h0, job_data[7:0]}, 32'h00);
    chk("load_byte75", {24'h0, job_data[607:600]}, 32'h4B);
    set_ready(1'b0);

    short_load(10);

    pulse_nonce(32'hDEADBEEF);
    nonce_read(5);
    status_read(1);

    hash_busy = 1'b1;
    pulse_nonce(32'h12345678);
    pulse_nonce(32'hCAFEF00D);
    open_frame(8'h02);
    send_tx(8'h0B);
    send_tx(8'h0B);
    close_frame();
    nonce_read(4);
    hash_busy = 1'b0;

    // Newest job wins while the first is still pending, then abort it
    rand_job(d); full_load(d, 0);
    rand_job(d); full_load(d, 1);
    chk("pending_valid", {31'h0, job_valid}, 32'h1);
    abort_op();
    status_read(1);

    // Nonce arriving in the same cycle the last nonce byte is consumed
    pulse_nonce(32'hA1B2C3D4);
    open_frame(8'h03);
    for (int k = 0; k < NB - 1; k++) send_tx(m_nonce[k*8 +: 8]);
    exp_tx_q.push_back(m_nonce[(NB-1)*8 +: 8]);
    nonce = 32'h0BADF00D; nonce_valid = 1'b1; send_byte = 1'b1;
    tick();
    nonce_valid = 1'b0; send_byte = 1'b0;
    m_found = 1'b1; m_overrun = 1'b0; m_nonce = 32'h0BADF00D;
    tick();
    close_frame();
    status_read(1);
    nonce_read(4);

    // Reset in the middle of a load, with a job already pending
    rand_job(d); full_load(d, 0);
    pulse_nonce(32'h55AA55AA);
    open_frame(8'h01);
    for (int i = 0; i < 40; i++) send_rx(8'($urandom));
    rst_n = 1'b0; #1;
    chk_reset_outputs("midload_rst");
    model_reset();
    tick();
    rst_n = 1'b1; tick(); tick();
    chk_reset_outputs("post_rst");
    close_frame();
    status_read(1);
    set_ready(1'b1);
    rand_job(d); full_load(d, 0);
    set_ready(1'b0);

    // Randomized mix of operations
    for (int it = 0; it < 40; it++) begin
      hash_busy = 1'($urandom);
      op = $urandom_range(0, 6);
      case (op)
        0: begin set_ready(1'($urandom)); rand_job(d); full_load(d, $urandom_range(0, 2)); end
        1: short_load($urandom_range(1, JB - 1));
        2: pulse_nonce($urandom);
        3: status_read($urandom_range(1, 3));
        4: nonce_read($urandom_range(1, 6));
        5: abort_op();
        default: begin
          open_frame(8'($urandom_range(5, 255)));
          send_rx(8'($urandom));
          close_frame();
          status_read(1);
        end
      endcase
    end
    set_ready(1'b1);
    tick(); tick();

    chk("tx_queue_empty", exp_tx_q.size(), 0);
    chk("job_queue_empty", exp_job_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
